// File: rtl/nibble_packer_if.sv
// rtl/nibble_packer_if.sv - nibble stream in, packed 24-bit word and status out
interface nibble_packer_if;
    logic [3:0]  in;
    logic        in_valid;
    logic        sof;
    logic [23:0] out;
    logic        out_valid;
    logic [2:0]  count;
    logic        drop;

    // Producer side: drives nibbles, observes packed words and status
    modport master (
        output in, in_valid, sof,
        input  out, out_valid, count, drop
    );

    // Packer side
    modport slave (
        input  in, in_valid, sof,
        output out, out_valid, count, drop
    );
endinterface

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs six MSB-first nibbles into a 24-bit word; optional idle timeout via NIBBLE_PACKER_TIMEOUT_EN
module nibble_packer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    nibble_packer_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t      state_q;
    // Holds up to five accepted nibbles; the sixth goes straight into out.
    logic [19:0] sr_q;
    logic [2:0]  count_q;
    logic [23:0] out_q;
    logic        out_valid_q;
    logic        drop_q;

    // Next shift-register value and completed word for an accepted nibble
    logic [19:0] sr_shift_d;
    logic [23:0] word_d;

`ifdef NIBBLE_PACKER_TIMEOUT_EN
    localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_q;
`endif

    // Combinational shift/concat of the incoming nibble onto held state
    always_comb begin
        sr_shift_d = {sr_q[15:0], bus.in};
        word_d     = {sr_q, bus.in};
    end

    // Packer FSM with registered outputs; reset wins over every other event
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            count_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
`ifdef NIBBLE_PACKER_TIMEOUT_EN
            idle_q      <= '0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Only a start-of-word nibble opens a word; stray nibbles are ignored
                    if (bus.in_valid && bus.sof) begin
                        sr_q    <= {16'b0, bus.in};
                        count_q <= 3'd1;
                        state_q <= FILL;
`ifdef NIBBLE_PACKER_TIMEOUT_EN
                        idle_q  <= '0;
`endif
                    end
                end
                FILL: begin
                    if (bus.in_valid) begin
`ifdef NIBBLE_PACKER_TIMEOUT_EN
                        idle_q <= '0;
`endif
                        if (bus.sof) begin
                            // New word arrives mid-fill: abandon the partial one
                            drop_q  <= 1'b1;
                            sr_q    <= {16'b0, bus.in};
                            count_q <= 3'd1;
                        end else if (count_q == 3'd5) begin
                            out_q       <= word_d;
                            out_valid_q <= 1'b1;
                            sr_q        <= '0;
                            count_q     <= 3'd0;
                            state_q     <= IDLE;
                        end else begin
                            sr_q    <= sr_shift_d;
                            count_q <= count_q + 3'd1;
                        end
                    end else begin
`ifdef NIBBLE_PACKER_TIMEOUT_EN
                        // The edge ending the TIMEOUT-th idle cycle discards the partial word
                        if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                            drop_q  <= 1'b1;
                            count_q <= 3'd0;
                            idle_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            idle_q <= idle_q + 1'b1;
                        end
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = count_q;
    assign bus.drop      = drop_q;

endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - table-driven and directed checks for nibble_packer
module tb_nibble_packer;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    nibble_packer_if bus ();

    nibble_packer #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic        s;
        logic [3:0]  n;
        logic [23:0] e_out;
        logic        e_ov;
        logic [2:0]  e_cnt;
        logic        e_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input logic r, input logic v, input logic s, input logic [3:0] n);
        @(negedge clk);
        reset        = r;
        bus.in_valid = v;
        bus.sof      = s;
        bus.in       = n;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [23:0] e_out, input logic e_ov,
                       input logic [2:0] e_cnt, input logic e_drop);
        n_vec++;
        if (bus.out !== e_out || bus.out_valid !== e_ov || bus.count !== e_cnt || bus.drop !== e_drop) begin
            n_bad++;
            $display("FAIL %s: got out=%h ov=%b cnt=%0d drop=%b, want out=%h ov=%b cnt=%0d drop=%b",
                     name, bus.out, bus.out_valid, bus.count, bus.drop, e_out, e_ov, e_cnt, e_drop);
        end
    endtask

    task automatic add(input string nm, input logic v, input logic s, input logic [3:0] n,
                       input logic [23:0] eo, input logic eov, input logic [2:0] ec, input logic ed);
        vec_t t;
        t.name = nm; t.v = v; t.s = s; t.n = n;
        t.e_out = eo; t.e_ov = eov; t.e_cnt = ec; t.e_drop = ed;
        vecs.push_back(t);
    endtask

    task automatic send_word(input string nm, input logic [23:0] w, input logic e_first_drop,
                             input logic [23:0] prev_out);
        logic [3:0] nib;
        for (int i = 0; i < 6; i++) begin
            nib = w[23 - 4*i -: 4];
            drive(1'b0, 1'b1, (i == 0), nib);
            if (i < 5)
                chk(nm, prev_out, 1'b0, 3'(i + 1), (i == 0) ? e_first_drop : 1'b0);
            else
                chk(nm, w, 1'b1, 3'd0, 1'b0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.sof = 1'b0;
        bus.in = 4'h0;

        // Basic word, idle hold, restart with drop, back-to-back, ignored nibbles
        add("w1_a", 1, 1, 4'hA, 24'h0, 0, 1, 0);
        add("w1_b", 1, 0, 4'hB, 24'h0, 0, 2, 0);
        add("w1_c", 1, 0, 4'hC, 24'h0, 0, 3, 0);
        add("w1_d", 1, 0, 4'hD, 24'h0, 0, 4, 0);
        add("w1_e", 1, 0, 4'hE, 24'h0, 0, 5, 0);
        add("w1_f", 1, 0, 4'hF, 24'hABCDEF, 1, 0, 0);
        add("w1_hold", 0, 0, 4'h0, 24'hABCDEF, 0, 0, 0);
        add("rs_1", 1, 1, 4'h1, 24'hABCDEF, 0, 1, 0);
        add("rs_2", 1, 0, 4'h2, 24'hABCDEF, 0, 2, 0);
        add("rs_3", 1, 0, 4'h3, 24'hABCDEF, 0, 3, 0);
        add("rs_9", 1, 1, 4'h9, 24'hABCDEF, 0, 1, 1);
        add("rs_8", 1, 0, 4'h8, 24'hABCDEF, 0, 2, 0);
        add("rs_7", 1, 0, 4'h7, 24'hABCDEF, 0, 3, 0);
        add("rs_6", 1, 0, 4'h6, 24'hABCDEF, 0, 4, 0);
        add("rs_5", 1, 0, 4'h5, 24'hABCDEF, 0, 5, 0);
        add("rs_4", 1, 0, 4'h4, 24'h987654, 1, 0, 0);
        add("b2b_1", 1, 1, 4'h1, 24'h987654, 0, 1, 0);
        add("b2b_2", 1, 0, 4'h2, 24'h987654, 0, 2, 0);
        add("b2b_3", 1, 0, 4'h3, 24'h987654, 0, 3, 0);
        add("b2b_4", 1, 0, 4'h4, 24'h987654, 0, 4, 0);
        add("b2b_5", 1, 0, 4'h5, 24'h987654, 0, 5, 0);
        add("b2b_6", 1, 0, 4'h6, 24'h123456, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            add("ign_7", 1, 0, 4'h7, 24'h123456, 0, 0, 0);
        add("ign_idle", 0, 0, 4'h0, 24'h123456, 0, 0, 0);

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        chk("reset_state", 24'h0, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        chk("reset_hold", 24'h0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].v, vecs[i].s, vecs[i].n);
            chk(vecs[i].name, vecs[i].e_out, vecs[i].e_ov, vecs[i].e_cnt, vecs[i].e_drop);
        end

        // Two-cycle gaps between nibbles
        drive(1'b0, 1'b1, 1'b1, 4'hA);
        chk("gap_a", 24'h123456, 0, 1, 0);
        for (int i = 1; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'h0);
            chk("gap_idle", 24'h123456, 0, 3'(i), 0);
            drive(1'b0, 1'b0, 1'b1, 4'h3);
            chk("gap_idle", 24'h123456, 0, 3'(i), 0);
            drive(1'b0, 1'b1, 1'b0, 4'(4'hA + i));
            if (i < 5) chk("gap_nib", 24'h123456, 0, 3'(i + 1), 0);
            else       chk("gap_done", 24'hABCDEF, 1, 0, 0);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        chk("gap_single_pulse", 24'hABCDEF, 0, 0, 0);

        // Idle timeout on a partial word
        drive(1'b0, 1'b1, 1'b1, 4'hA);
        drive(1'b0, 1'b1, 1'b0, 4'hB);
        drive(1'b0, 1'b1, 1'b0, 4'hC);
        chk("to_fill", 24'hABCDEF, 0, 3, 0);
        for (int i = 1; i <= 15; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'h0);
`ifdef NIBBLE_PACKER_TIMEOUT_EN
            if (i < 15) chk("to_wait", 24'hABCDEF, 0, 3, 0);
            else        chk("to_drop", 24'hABCDEF, 0, 0, 1);
`else
            chk("to_hold", 24'hABCDEF, 0, 3, 0);
`endif
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
`ifdef NIBBLE_PACKER_TIMEOUT_EN
        chk("to_after", 24'hABCDEF, 0, 0, 0);
        send_word("to_next", 24'h2468AC, 1'b0, 24'hABCDEF);
`else
        chk("to_after", 24'hABCDEF, 0, 3, 0);
        send_word("to_next", 24'h2468AC, 1'b1, 24'hABCDEF);
`endif

        // Reset mid-fill, with in_valid&sof asserted in the same cycle
        drive(1'b0, 1'b1, 1'b1, 4'h1);
        drive(1'b0, 1'b1, 1'b0, 4'h2);
        drive(1'b0, 1'b1, 1'b0, 4'h3);
        drive(1'b0, 1'b1, 1'b0, 4'h4);
        chk("rst_pre", 24'h2468AC, 0, 4, 0);
        drive(1'b1, 1'b1, 1'b1, 4'h5);
        chk("rst_mid", 24'h0, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        chk("rst_after", 24'h0, 0, 0, 0);
        send_word("rst_next", 24'hFEDCBA, 1'b0, 24'h0);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        chk("rst_next_hold", 24'hFEDCBA, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
